rx_cmd_parser: RTL and testbench

- Frame decoder directly downstream of the UART receiver.
- Consumes received bytes (data plus valid strobe and per-byte error flags) and assembles multi-byte command frames.
- Issues single-cycle register-file write/read and ALU commands to the system controller datapath.
- Runs in the RX clock domain; abandons malformed or stalled frames.

---
 rtl/uart_sys_pkg.sv | 25 ++
 rtl/rx_cmd_timeout.sv | 30 +++
 rtl/rx_cmd_parser.sv | 144 ++++++++++++++
 tb/tb_rx_cmd_parser.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: opcode values and the
// frame-parser state encoding.
package uart_sys_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Encoding 3'd7 is unused; the parser treats it as a recovery state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_A   = 3'd4,
    ST_ALU_B   = 3'd5,
    ST_ALU_FN  = 3'd6
  } rx_state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == CMD_WR) || (b == CMD_RD) || (b == CMD_ALU_OP) || (b == CMD_ALU_NOP);
  endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte idle counter: counts enabled cycles and fires a single-cycle
// expire pulse on the last allowed cycle, clearing itself at the same time.
module rx_cmd_timeout #(
  parameter int CYCLES = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rx_cmd_parser.sv
// Assembles UART bytes into write/read/ALU command frames and issues
// single-cycle command pulses; corrupted, unknown or stalled frames pulse FRM_ERR.
module rx_cmd_parser
  import uart_sys_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  output logic                  FRM_ERR,
  output logic                  BUSY
);

  rx_state_e r_state, w_state_next;

  logic       w_accept, w_corrupt, w_legal, w_unknown;
  logic       w_expire, w_to_clr, w_to_en;
  logic [7:0] w_opcode;

  logic w_wr_en_next, w_rd_en_next, w_alu_en_next, w_frm_err_next;
  logic w_ld_addr, w_ld_data, w_ld_a, w_ld_b, w_ld_fun;

  logic                  r_wr_en, r_rd_en, r_alu_en, r_frm_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data, r_op_a, r_op_b;
  logic [FUN_WIDTH-1:0]  r_alu_fun;

  assign w_accept  = RX_D_VLD && !RX_PAR_ERR && !RX_STP_ERR;
  assign w_corrupt = RX_D_VLD && (RX_PAR_ERR || RX_STP_ERR);
  assign w_opcode  = RX_P_DATA[7:0];
  assign w_legal   = (r_state <= ST_ALU_FN);
  assign w_unknown = (r_state == ST_IDLE) && w_accept && !is_opcode(w_opcode);

  assign w_to_clr = (r_state == ST_IDLE) || w_accept;
  assign w_to_en  = (r_state != ST_IDLE) && !RX_D_VLD;

  rx_cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!w_legal) begin
      w_state_next = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        case (w_opcode)
          CMD_WR:      w_state_next = ST_WR_ADDR;
          CMD_RD:      w_state_next = ST_RD_ADDR;
          CMD_ALU_OP:  w_state_next = ST_ALU_A;
          CMD_ALU_NOP: w_state_next = ST_ALU_FN;
          default:     w_state_next = ST_IDLE;
        endcase
      end
    end else if (w_corrupt || w_expire) begin
      w_state_next = ST_IDLE;
    end else if (w_accept) begin
      case (r_state)
        ST_WR_ADDR: w_state_next = ST_WR_DATA;
        ST_ALU_A:   w_state_next = ST_ALU_B;
        ST_ALU_B:   w_state_next = ST_ALU_FN;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // Only one byte can be seen per edge, so the pulse sources are mutually exclusive.
  always_comb begin
    w_wr_en_next   = w_accept && (r_state == ST_WR_DATA);
    w_rd_en_next   = w_accept && (r_state == ST_RD_ADDR);
    w_alu_en_next  = w_accept && (r_state == ST_ALU_FN);
    w_frm_err_next = w_legal && (w_corrupt || w_unknown || w_expire);
    w_ld_addr      = w_accept && ((r_state == ST_WR_ADDR) || (r_state == ST_RD_ADDR));
    w_ld_data      = w_accept && (r_state == ST_WR_DATA);
    w_ld_a         = w_accept && (r_state == ST_ALU_A);
    w_ld_b         = w_accept && (r_state == ST_ALU_B);
    w_ld_fun       = w_accept && (r_state == ST_ALU_FN);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_frm_err <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_alu_fun <= '0;
    end else begin
      r_wr_en   <= w_wr_en_next;
      r_rd_en   <= w_rd_en_next;
      r_alu_en  <= w_alu_en_next;
      r_frm_err <= w_frm_err_next;
      if (w_ld_addr) r_addr    <= RX_P_DATA[ADDR_WIDTH-1:0];
      if (w_ld_data) r_wr_data <= RX_P_DATA;
      if (w_ld_a)    r_op_a    <= RX_P_DATA;
      if (w_ld_b)    r_op_b    <= RX_P_DATA;
      if (w_ld_fun)  r_alu_fun <= RX_P_DATA[FUN_WIDTH-1:0];
    end
  end

  assign WR_EN   = r_wr_en;
  assign RD_EN   = r_rd_en;
  assign ALU_EN  = r_alu_en;
  assign FRM_ERR = r_frm_err;
  assign ADDR    = r_addr;
  assign WR_DATA = r_wr_data;
  assign ALU_FUN = r_alu_fun;
  assign OP_A    = r_op_a;
  assign OP_B    = r_op_b;
  assign BUSY    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Scoreboard bench for rx_cmd_parser: stimulus pushes expected command pulses,
// a negedge monitor pops and compares them against what the parser issues.
module tb_rx_cmd_parser;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ALU = 2;
  localparam int K_ERR = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       RX_PAR_ERR = 1'b0;
  logic       RX_STP_ERR = 1'b0;
  logic       WR_EN, RD_EN, ALU_EN, FRM_ERR, BUSY;
  logic [3:0] ADDR, ALU_FUN;
  logic [7:0] WR_DATA, OP_A, OP_B;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] fun;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rx_cmd_parser #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .FUN_WIDTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RX_PAR_ERR (RX_PAR_ERR),
    .RX_STP_ERR (RX_STP_ERR),
    .WR_EN      (WR_EN),
    .RD_EN      (RD_EN),
    .ADDR       (ADDR),
    .WR_DATA    (WR_DATA),
    .ALU_EN     (ALU_EN),
    .ALU_FUN    (ALU_FUN),
    .OP_A       (OP_A),
    .OP_B       (OP_B),
    .FRM_ERR    (FRM_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] fun, input logic [7:0] a, input logic [7:0] b,
                          input int c);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = addr; e.data = data;
    e.fun = fun; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic par, input logic stp);
    RX_P_DATA  = d;
    RX_D_VLD   = 1'b1;
    RX_PAR_ERR = par;
    RX_STP_ERR = stp;
    @(posedge CLK);
    #1;
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_STP_ERR = 1'b0;
    $display("byte 0x%02h par=%0b stp=%0b accepted at cycle %0d busy=%0b", d, par, stp, cyc, BUSY);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: every issued pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    int   n_hi;
    int   kind;
    exp_t e;
    if (RST && (WR_EN || RD_EN || ALU_EN || FRM_ERR)) begin
      n_hi = int'(WR_EN) + int'(RD_EN) + int'(ALU_EN) + int'(FRM_ERR);
      check("pulse_exclusive", n_hi, 1);
      kind = FRM_ERR ? K_ERR : (WR_EN ? K_WR : (RD_EN ? K_RD : K_ALU));
      $display("pulse kind=%0d cycle=%0d addr=%0h wr_data=%02h fun=%0h op_a=%02h op_b=%02h",
               kind, cyc, ADDR, WR_DATA, ALU_FUN, OP_A, OP_B);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse actual kind=%0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        case (e.kind)
          K_WR: begin
            check("wr_addr", {28'd0, ADDR}, {24'd0, e.addr});
            check("wr_data", {24'd0, WR_DATA}, {24'd0, e.data});
          end
          K_RD: check("rd_addr", {28'd0, ADDR}, {24'd0, e.addr});
          K_ALU: begin
            check("alu_fun", {28'd0, ALU_FUN}, {24'd0, e.fun});
            check("op_a", {24'd0, OP_A}, {24'd0, e.a});
            check("op_b", {24'd0, OP_B}, {24'd0, e.b});
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset state
    idle(3);
    check("reset_pulses_busy", {27'd0, WR_EN, RD_EN, ALU_EN, FRM_ERR, BUSY}, 32'd0);
    check("reset_fields", {ADDR, WR_DATA, ALU_FUN, OP_A, OP_B}, 32'd0);
    RST = 1'b1;
    idle(2);

    // Write with gaps
    send_byte(8'hAA, 1'b0, 1'b0);
    check("busy_after_op", {31'd0, BUSY}, 32'd1);
    idle(10);
    send_byte(8'h05, 1'b0, 1'b0);
    check("busy_after_addr", {31'd0, BUSY}, 32'd1);
    idle(10);
    send_byte(8'h3C, 1'b0, 1'b0);
    push_exp(K_WR, 8'h05, 8'h3C, 8'h0, 8'h0, 8'h0, cyc);
    check("busy_after_wr_frame", {31'd0, BUSY}, 32'd0);
    idle(4);

    // Read then ALU, back-to-back
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    push_exp(K_RD, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, cyc);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    push_exp(K_ALU, 8'h0, 8'h0, 8'h01, 8'h07, 8'h03, cyc);

    // ALU without operands keeps OP_A/OP_B
    send_byte(8'hDD, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    push_exp(K_ALU, 8'h0, 8'h0, 8'h04, 8'h07, 8'h03, cyc);
    idle(3);

    // Corrupted byte aborts the frame, next frame works
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    push_exp(K_ERR, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, cyc);
    check("busy_after_abort", {31'd0, BUSY}, 32'd0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    push_exp(K_WR, 8'h01, 8'hFF, 8'h0, 8'h0, 8'h0, cyc);
    idle(3);

    // Timeout after 16 silent cycles, late byte becomes an unknown opcode
    send_byte(8'hAA, 1'b0, 1'b0);
    push_exp(K_ERR, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, cyc + 16);
    idle(15);
    check("busy_before_timeout", {31'd0, BUSY}, 32'd1);
    idle(1);
    check("busy_after_timeout", {31'd0, BUSY}, 32'd0);
    send_byte(8'h11, 1'b0, 1'b0);
    push_exp(K_ERR, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, cyc);
    idle(3);

    // Reset in the middle of an ALU frame
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0, 1'b0);
    RST = 1'b0;
    idle(1);
    check("midreset_pulses_busy", {27'd0, WR_EN, RD_EN, ALU_EN, FRM_ERR, BUSY}, 32'd0);
    check("midreset_fields", {ADDR, WR_DATA, ALU_FUN, OP_A, OP_B}, 32'd0);
    RST = 1'b1;
    send_byte(8'h03, 1'b0, 1'b0);
    push_exp(K_ERR, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, cyc);
    idle(6);

    check("all_expected_pulses_seen", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
